axi_rd_arb: RTL
===============

// Module: axi_rd_arb
// PURPOSE
//  Round-robin arbiter sharing the single AXI read interface (lsu_axi_*/axi_lsu_* side) between NUM_REQ load requesters (e.g. weight loader, activation loader).
//  Grants one requester at a time. Holds the grant for the whole strided load: AR issue plus all response bursts.
//  Routes read beats back to the owner only. Sits between the requesters and the AXI read interface block.
// PARAMETERS
//  NUM_REQ       2   number of requesters (2..8)
//  REQ_IDX_W     1   clog2(NUM_REQ)
//  ARADDR_WIDTH  10  address width, matches AXI read interface
//  RDATA_WIDTH   64  read data width
// PORTS
//  clk             in   1                  clock; single clock domain
//  rst_n           in   1                  reset; asynchronous, active-low
//  req_arvld       in   NUM_REQ            per-requester load request valid
//  req_araddr      in   NUM_REQ*ARADDR_W   packed start address, slice i = requester i
//  req_arlen       in   NUM_REQ*8          packed AXI burst length (beats-1)
//  req_arsize      in   NUM_REQ*3          packed AXI size
//  req_arburst     in   NUM_REQ*2          packed AXI burst type
//  req_arstr       in   NUM_REQ*3          packed stride code (0:16 1:32 2:64 3:128 4:256)
//  req_arnum       in   NUM_REQ*8          packed number of bursts in the load (0 treated as 1)
//  req_arrdy       out  NUM_REQ            one-hot 1-cycle accept pulse
//  req_rvld        out  NUM_REQ            one-hot read beat valid, owner only
//  req_rdata       out  RDATA_WIDTH        broadcast read data
//  req_rresp       out  2                  broadcast read response
//  req_rlast       out  1                  broadcast last-beat flag
//  req_rrdy        in   NUM_REQ            per-requester beat ready
//  lsu_axi_arvld   out  1                  registered; to AXI read interface
//  lsu_axi_araddr/arlen/arsize/arburst/arstr/arnum  out  as above  registered copy of granted request
//  lsu_axi_arid    out  8                  {zero-pad, owner index}
//  axi_lsu_arrdy   in   1                  interface idle/accept
//  axi_lsu_rvld/rdata/rresp/rlast  in      read beat from interface
//  lsu_axi_rrdy    out  1                  beat accept to interface
//  arb_busy        out  1                  state != IDLE
//  arb_owner       out  NUM_REQ            one-hot current owner, 0 in IDLE
//  arb_err         out  1                  sticky: any beat with rresp != 0; cleared only by reset
// BEHAVIOUR
//  Reset values: every output 0; state IDLE; rr pointer = NUM_REQ-1, so req 0 wins first.
//  FSM IDLE -> ISSUE -> RESP -> IDLE.
//  IDLE:
//   - Any req_arvld set: rr pick = first set bit after the pointer, wrapping.
//   - Same cycle: req_arrdy[pick] = 1, capture its fields into lsu_axi_* regs, pointer <= pick, owner <= pick, bcnt <= 0. Next state ISSUE.
//   - No request: stay in IDLE.
//  ISSUE:
//   - lsu_axi_arvld = 1 (first high 1 cycle after the accept).
//   - On lsu_axi_arvld & axi_lsu_arrdy: go to RESP, arvld drops next cycle.
//   - Captured fields stay stable while arvld is high.
//  RESP:
//   - req_rvld = owner & {NUM_REQ{axi_lsu_rvld}}.
//   - lsu_axi_rrdy = req_rrdy[owner]. Comb path, zero added latency.
//   - Beat handshake: axi_lsu_rvld & lsu_axi_rrdy.
//   - A handshake with rlast increments the 8-bit bcnt.
//   - A handshake with rlast while bcnt == max(arnum,1)-1 goes to IDLE next cycle. A new grant is possible in that IDLE cycle.
//  Outside RESP: lsu_axi_rrdy = 0 and req_rvld = 0. A stray beat stalls and is never dropped.
//  Requests arriving in ISSUE/RESP are held off: req_arrdy = 0, and the requester keeps arvld high.
//  A request deasserted before its grant is simply not granted.
//  Simultaneous requests: exactly one granted; the others are served in rr order on later IDLE cycles.
//  No starvation: each requester waits at most NUM_REQ-1 loads.
//  arb_err sets on any beat handshake with rresp != 0. It does not abort the load.
//  Reset mid-load: everything returns to reset values immediately. In-flight beats are not tracked, and the interface must be reset together.
// STRUCTURE
//  Shared package axi_rd_pkg:
//   - state localparams ST_IDLE/ST_ISSUE/ST_RESP (2-bit).
//   - AXI_RESP_OKAY=2'b00, AXI_BURST_INCR=2'b01.
//   - stride code constants.
//  Sub-module rr_arb #(NUM_REQ): comb inputs req vector + pointer; outputs one-hot grant and encoded index.
//  Top: FSM, capture regs (DFFRE), bcnt, owner, pointer, err flop, beat mux.
// TESTING
//  1. Single req0: addr=0x040, arlen=3, arnum=2.
//     -> req_arrdy[0] at T; lsu_axi_arvld at T+1; after 2 rlast beats (8 total) arb_busy=0.
//  2. req0 and req1 both high at reset exit.
//     -> req0 granted first, then req1.
//     Then repeat with both high -> req1? No: pointer=1 so req0 is granted, giving alternation 0,1,0,1.
//  3. axi_lsu_arrdy held 0 for 5 cycles in ISSUE.
//     -> arvld stays high and araddr stable; RESP entered the cycle after arrdy rises.
//  4. req_rrdy[owner] toggled 1/0 each cycle.
//     -> lsu_axi_rrdy mirrors it; no beat lost or duplicated; the other req_rvld stays 0.
//  5. Beat with rresp=2'b10 mid-load.
//     -> arb_err=1 from the next cycle, load completes normally, err stays set until rst_n.
//  6. rst_n asserted during RESP.
//     -> all outputs 0 asynchronously; after release req0 is granted first again.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the AXI read arbiter slice.
package axi_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [2:0] STR_16  = 3'd0;
  localparam logic [2:0] STR_32  = 3'd1;
  localparam logic [2:0] STR_64  = 3'd2;
  localparam logic [2:0] STR_128 = 3'd3;
  localparam logic [2:0] STR_256 = 3'd4;

  // Index of the final burst; a burst count of 0 means a single burst.
  function automatic logic [7:0] last_burst(input logic [7:0] arnum);
    return (arnum == 8'd0) ? 8'd0 : arnum - 8'd1;
  endfunction

endpackage

// File: rtl/axi_rd_arb_if.sv
// Requester-side and AXI-read-side bus bundle for axi_rd_arb.
interface axi_rd_arb_if #(
  parameter int NUM_REQ      = 2,
  parameter int ARADDR_WIDTH = 10,
  parameter int RDATA_WIDTH  = 64
);
  logic [NUM_REQ-1:0]              req_arvld;
  logic [NUM_REQ*ARADDR_WIDTH-1:0] req_araddr;
  logic [NUM_REQ*8-1:0]            req_arlen;
  logic [NUM_REQ*3-1:0]            req_arsize;
  logic [NUM_REQ*2-1:0]            req_arburst;
  logic [NUM_REQ*3-1:0]            req_arstr;
  logic [NUM_REQ*8-1:0]            req_arnum;
  logic [NUM_REQ-1:0]              req_arrdy;
  logic [NUM_REQ-1:0]              req_rvld;
  logic [RDATA_WIDTH-1:0]          req_rdata;
  logic [1:0]                      req_rresp;
  logic                            req_rlast;
  logic [NUM_REQ-1:0]              req_rrdy;

  logic                    lsu_axi_arvld;
  logic [ARADDR_WIDTH-1:0] lsu_axi_araddr;
  logic [7:0]              lsu_axi_arlen;
  logic [2:0]              lsu_axi_arsize;
  logic [1:0]              lsu_axi_arburst;
  logic [2:0]              lsu_axi_arstr;
  logic [7:0]              lsu_axi_arnum;
  logic [7:0]              lsu_axi_arid;
  logic                    axi_lsu_arrdy;
  logic                    axi_lsu_rvld;
  logic [RDATA_WIDTH-1:0]  axi_lsu_rdata;
  logic [1:0]              axi_lsu_rresp;
  logic                    axi_lsu_rlast;
  logic                    lsu_axi_rrdy;

  modport slave (
    input  req_arvld, req_araddr, req_arlen, req_arsize, req_arburst, req_arstr,
           req_arnum, req_rrdy, axi_lsu_arrdy, axi_lsu_rvld, axi_lsu_rdata,
           axi_lsu_rresp, axi_lsu_rlast,
    output req_arrdy, req_rvld, req_rdata, req_rresp, req_rlast, lsu_axi_arvld,
           lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
           lsu_axi_arstr, lsu_axi_arnum, lsu_axi_arid, lsu_axi_rrdy
  );

  modport master (
    output req_arvld, req_araddr, req_arlen, req_arsize, req_arburst, req_arstr,
           req_arnum, req_rrdy, axi_lsu_arrdy, axi_lsu_rvld, axi_lsu_rdata,
           axi_lsu_rresp, axi_lsu_rlast,
    input  req_arrdy, req_rvld, req_rdata, req_rresp, req_rlast, lsu_axi_arvld,
           lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize, lsu_axi_arburst,
           lsu_axi_arstr, lsu_axi_arnum, lsu_axi_arid, lsu_axi_rrdy
  );
endinterface

// File: rtl/axi_rd_arb_rr_arb.sv
// Combinational round-robin pick: first request strictly after ptr, wrapping.
module rr_arb #(
  parameter int NUM_REQ   = 2,
  parameter int REQ_IDX_W = 1
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [REQ_IDX_W-1:0] idx,
  output logic                 vld
);
  int unsigned          cand;
  logic [REQ_IDX_W-1:0] cidx;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    vld  = 1'b0;
    cand = 0;
    cidx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = (32'(ptr) + k) % NUM_REQ;
      cidx = REQ_IDX_W'(cand);
      if (!vld && req[cidx]) begin
        vld       = 1'b1;
        gnt[cidx] = 1'b1;
        idx       = cidx;
      end
    end
  end
endmodule

// File: rtl/axi_rd_arb.sv
// Round-robin owner of the single AXI read interface; holds the grant for a
// whole strided load (AR issue plus every response burst).
module axi_rd_arb
  import axi_rd_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int REQ_IDX_W    = 1,
  parameter int ARADDR_WIDTH = 10,
  parameter int RDATA_WIDTH  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_rd_arb_if.slave        bus,
  output logic               arb_busy,
  output logic [NUM_REQ-1:0] arb_owner,
  output logic               arb_err
);
  arb_state_e           state;
  logic [REQ_IDX_W-1:0] rr_ptr;
  logic [REQ_IDX_W-1:0] owner_idx;
  logic [REQ_IDX_W-1:0] pick_idx;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic                 pick_vld;
  logic                 in_resp;
  logic                 rrdy;
  logic                 beat;
  logic [7:0]           bcnt;

  rr_arb #(.NUM_REQ(NUM_REQ), .REQ_IDX_W(REQ_IDX_W)) u_rr_arb (
    .req (bus.req_arvld),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Accept pulse is gated by rst_n so requesters see nothing while in reset.
  always_comb begin
    in_resp          = (state == ST_RESP);
    rrdy             = in_resp & bus.req_rrdy[owner_idx];
    beat             = rrdy & bus.axi_lsu_rvld;
    bus.lsu_axi_rrdy = rrdy;
    bus.req_arrdy    = (rst_n && state == ST_IDLE) ? pick_gnt : '0;
    bus.req_rvld     = in_resp ? (arb_owner & {NUM_REQ{bus.axi_lsu_rvld}}) : '0;
    bus.req_rdata    = in_resp ? bus.axi_lsu_rdata : '0;
    bus.req_rresp    = in_resp ? bus.axi_lsu_rresp : '0;
    bus.req_rlast    = in_resp & bus.axi_lsu_rlast;
  end

  assign arb_busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      rr_ptr              <= REQ_IDX_W'(NUM_REQ - 1);
      owner_idx           <= '0;
      arb_owner           <= '0;
      bcnt                <= '0;
      arb_err             <= 1'b0;
      bus.lsu_axi_arvld   <= 1'b0;
      bus.lsu_axi_araddr  <= '0;
      bus.lsu_axi_arlen   <= '0;
      bus.lsu_axi_arsize  <= '0;
      bus.lsu_axi_arburst <= '0;
      bus.lsu_axi_arstr   <= '0;
      bus.lsu_axi_arnum   <= '0;
      bus.lsu_axi_arid    <= '0;
    end else begin
      if (beat && bus.axi_lsu_rresp != AXI_RESP_OKAY) begin
        arb_err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            bus.lsu_axi_arvld   <= 1'b1;
            bus.lsu_axi_araddr  <= bus.req_araddr[pick_idx*ARADDR_WIDTH +: ARADDR_WIDTH];
            bus.lsu_axi_arlen   <= bus.req_arlen[pick_idx*8 +: 8];
            bus.lsu_axi_arsize  <= bus.req_arsize[pick_idx*3 +: 3];
            bus.lsu_axi_arburst <= bus.req_arburst[pick_idx*2 +: 2];
            bus.lsu_axi_arstr   <= bus.req_arstr[pick_idx*3 +: 3];
            bus.lsu_axi_arnum   <= bus.req_arnum[pick_idx*8 +: 8];
            bus.lsu_axi_arid    <= 8'(pick_idx);
            rr_ptr              <= pick_idx;
            owner_idx           <= pick_idx;
            arb_owner           <= pick_gnt;
            bcnt                <= '0;
            state               <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.axi_lsu_arrdy) begin
            bus.lsu_axi_arvld <= 1'b0;
            state             <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (beat && bus.axi_lsu_rlast) begin
            bcnt <= bcnt + 8'd1;
            if (bcnt == last_burst(bus.lsu_axi_arnum)) begin
              arb_owner <= '0;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
